spi_burst_dcd: RTL and testbench
================================

Name: spi_burst_dcd

Overview:
Parametrised successor to the single-access SPI instruction decoder. Sits between the SPI slave byte interface and the peripheral register file. Decodes a command byte, then performs one or a burst of auto-incrementing register reads or writes. The burst ends on frame end or at a programmable length limit, with overflow reporting.

Parameters:
ADDR_W, 6, register address width (1..6); taken from cmd[ADDR_W-1:0], upper cmd[5:ADDR_W] bits ignored
MAX_BURST, 16, max data bytes per burst frame (1..64)
CNT_W, 7, width of internal byte counter; must hold MAX_BURST

Ports:
clk  in  1  peripheral clock
rst_n  in  1  asynchronous active-low reset
byte_sync  in  1  one-cycle pulse: data_in holds a complete received byte
data_in  in  8  received SPI byte
frame_end  in  1  one-cycle pulse: chip select deasserted, frame finished
data_out  out  8  byte presented to SPI slave for next shift-out (registered)
read  out  1  register read strobe, 1 cycle
write  out  1  register write strobe, 1 cycle
addr  out  ADDR_W  register address for read/write
data_read  in  8  register file read data, combinational from addr while read=1
data_write  out  8  register write data, valid with write
busy  out  1  high in any state except IDLE
ovf  out  1  one-cycle pulse: data byte received beyond MAX_BURST

Behaviour:
- Reset (async, rst_n=0): state IDLE; read, write, ovf=0; addr=0; data_write=0; data_out=0x00; counter=0; busy=0.
- read, write, ovf default to 0 every cycle; only pulses.
- Command byte: [7]=op (1 write, 0 read), [6]=burst (1 auto-increment), [5:0]=address.
- States: IDLE, WDATA, RDATA, DROP.
- IDLE + byte_sync: latch op, burst, addr=cmd[ADDR_W-1:0], counter=0.
  - Write: go WDATA.
  - Read: go RDATA; read=1 in next cycle with that addr (look-ahead).
- Read data capture: on every cycle with read=1, data_out <= data_read. Visible 2 cycles after the triggering byte_sync.
- WDATA + byte_sync: next cycle write=1, data_write=data_in, addr=current. Counter increments.
  - Non-burst: go IDLE.
  - Burst: addr increments one cycle after the write pulse. If counter reaches MAX_BURST, go DROP, else stay.
- RDATA + byte_sync: the byte just shifted out is consumed. Counter increments.
  - Non-burst: go IDLE, no new read.
  - Burst and counter<MAX_BURST: addr+1, read=1 next cycle.
  - Burst and counter==MAX_BURST: go DROP, no read.
- DROP + byte_sync: ovf=1 next cycle, no read/write, data_out=0x00; stay in DROP until frame_end.
- Address arithmetic: modulo 2^ADDR_W; (2^ADDR_W)-1 wraps to 0, no flag.
- frame_end in any state: go IDLE next cycle, counter=0. It overrides a simultaneous byte_sync: that byte is discarded, no strobe. Strobes already scheduled for the current cycle still complete.
- MAX_BURST=1: burst bit has no effect beyond entering DROP after the first data byte.
- Mid-operation reset: aborts immediately, no pending strobe survives.

Optional Feature:
SPI_BURST_DCD_ECHO_EN
- Defined: in WDATA, data_out <= data_in on each byte_sync, so the host reads back the previous written byte as a link check.
- Undefined: data_out holds its last value through writes, i.e. 0x00 after reset or the last read data.
- Read behaviour is identical either way.

Test Plan:
- Single write: cmd 0x85, then 0x3C -> one write pulse, addr=5, data_write=0x3C; state IDLE; busy low.
- Single read: cmd 0x0A with reg[10]=0x77 -> read pulse 1 cycle after the cmd byte_sync, addr=10; data_out=0x77; 0 further reads after the dummy byte.
- Burst write wrap (ADDR_W=6): cmd 0xFE, data 0x11,0x22,0x33 -> writes at addr 62,63,0 with those data; frame_end -> IDLE.
- Burst read limit (MAX_BURST=4): cmd 0x40 plus 5 dummy bytes -> reads at addr 0,1,2,3 only; 5th byte gives ovf pulse; data_out=0x00; frame_end clears.
- Collision: byte_sync and frame_end in the same cycle in WDATA -> no write pulse; state IDLE; next byte treated as command.
- Reset mid-burst: rst_n low during RDATA -> all outputs 0 immediately; after release, cmd 0x83 works normally.

Source files
------------

// File: rtl/spi_burst_dcd.sv
// spi_burst_dcd: SPI command decoder with single or auto-incrementing burst
// register reads and writes, a per-frame length limit and overflow pulse.
// Optional build macro SPI_BURST_DCD_ECHO_EN: echo each written byte on
// data_out so the host can read it back as a link check.
module spi_burst_dcd #(
    parameter int ADDR_W    = 6,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    input  logic              frame_end,
    output logic [7:0]        data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_read,
    output logic [7:0]        data_write,
    output logic              busy,
    output logic              ovf
);

    typedef enum logic [1:0] {IDLE, WDATA, RDATA, DROP} state_t;

    state_t            state_q, state_d;
    logic              burst_q, burst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        dout_d, dw_d;
    logic              read_d, write_d, ovf_d;
    logic              at_limit;

    assign busy     = (state_q != IDLE);
    assign cnt_inc  = cnt_q + 1'b1;
    assign at_limit = (cnt_inc == CNT_W'(MAX_BURST));

    // Register all state and the pulsed/held outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            burst_q    <= 1'b0;
            cnt_q      <= '0;
            addr       <= '0;
            data_out   <= 8'h00;
            data_write <= 8'h00;
            read       <= 1'b0;
            write      <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            cnt_q      <= cnt_d;
            addr       <= addr_d;
            data_out   <= dout_d;
            data_write <= dw_d;
            read       <= read_d;
            write      <= write_d;
            ovf        <= ovf_d;
        end
    end

    // Next-state decode; strobes default low and last exactly one cycle.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        addr_d  = addr;
        dout_d  = data_out;
        dw_d    = data_write;
        read_d  = 1'b0;
        write_d = 1'b0;
        ovf_d   = 1'b0;

        // A read already issued completes even if the frame ends now.
        if (read) dout_d = data_read;
        // Burst writes advance the address one cycle after the strobe; a new
        // command below overrides this.
        if (write && burst_q) addr_d = addr + 1'b1;

        if (frame_end) begin
            // Frame end wins over a coincident byte, which is dropped.
            state_d = IDLE;
            cnt_d   = '0;
        end else if (byte_sync) begin
            unique case (state_q)
                IDLE: begin
                    burst_d = data_in[6];
                    addr_d  = data_in[ADDR_W-1:0];
                    cnt_d   = '0;
                    if (data_in[7]) begin
                        state_d = WDATA;
                    end else begin
                        state_d = RDATA;
                        read_d  = 1'b1;   // look-ahead fetch of the first byte
                    end
                end
                WDATA: begin
                    write_d = 1'b1;
                    dw_d    = data_in;
                    cnt_d   = cnt_inc;
`ifdef SPI_BURST_DCD_ECHO_EN
                    dout_d  = data_in;
`endif
                    if (!burst_q)     state_d = IDLE;
                    else if (at_limit) state_d = DROP;
                end
                RDATA: begin
                    cnt_d = cnt_inc;
                    if (!burst_q) begin
                        state_d = IDLE;
                    end else if (at_limit) begin
                        state_d = DROP;
                    end else begin
                        addr_d = addr + 1'b1;
                        read_d = 1'b1;
                    end
                end
                DROP: begin
                    ovf_d  = 1'b1;
                    dout_d = 8'h00;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_dcd.sv
// Directed bench for spi_burst_dcd (ADDR_W=6, MAX_BURST=4).
module tb_spi_burst_dcd;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       byte_sync = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       frame_end = 1'b0;
    logic [7:0] data_out;
    logic       read, write, busy, ovf;
    logic [5:0] addr;
    logic [7:0] data_read;
    logic [7:0] data_write;
    logic [7:0] regs [64];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Register file model: combinational read from addr.
    assign data_read = regs[addr];

    spi_burst_dcd #(.ADDR_W(6), .MAX_BURST(4), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .byte_sync(byte_sync), .data_in(data_in),
        .frame_end(frame_end), .data_out(data_out), .read(read), .write(write),
        .addr(addr), .data_read(data_read), .data_write(data_write),
        .busy(busy), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte for one cycle; returns at the negedge where its effect shows.
    task automatic send(input logic [7:0] b);
        byte_sync = 1'b1;
        data_in   = b;
        @(negedge clk);
        byte_sync = 1'b0;
    endtask

    task automatic frame(input logic with_byte, input logic [7:0] b);
        frame_end = 1'b1;
        byte_sync = with_byte;
        data_in   = b;
        @(negedge clk);
        frame_end = 1'b0;
        byte_sync = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) regs[i] = 8'hA0 + 8'(i);
        regs[10] = 8'h77;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_read", {15'd0, read}, 16'd0);
        chk("rst_write", {15'd0, write}, 16'd0);
        chk("rst_ovf", {15'd0, ovf}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_addr", {10'd0, addr}, 16'd0);
        chk("rst_dw", {8'd0, data_write}, 16'd0);
        chk("rst_dout", {8'd0, data_out}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write: 0x85, 0x3C
        send(8'h85);
        chk("sw_busy_cmd", {15'd0, busy}, 16'd1);
        chk("sw_nowrite_cmd", {15'd0, write}, 16'd0);
        send(8'h3C);
        chk("sw_write", {15'd0, write}, 16'd1);
        chk("sw_addr", {10'd0, addr}, 16'd5);
        chk("sw_dw", {8'd0, data_write}, 16'h3C);
        chk("sw_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        chk("sw_write_end", {15'd0, write}, 16'd0);
        chk("sw_addr_hold", {10'd0, addr}, 16'd5);
        chk("sw_dout_hold", {8'd0, data_out}, 16'h00);

        // Single read: 0x0A, reg[10]=0x77
        send(8'h0A);
        chk("sr_read", {15'd0, read}, 16'd1);
        chk("sr_addr", {10'd0, addr}, 16'd10);
        @(negedge clk);
        chk("sr_read_end", {15'd0, read}, 16'd0);
        chk("sr_dout", {8'd0, data_out}, 16'h77);
        send(8'h00);
        chk("sr_dummy_noread", {15'd0, read}, 16'd0);
        chk("sr_idle", {15'd0, busy}, 16'd0);
        @(negedge clk);
        chk("sr_dummy_noread2", {15'd0, read}, 16'd0);

        // Burst write with address wrap: 0xFE, 11, 22, 33
        send(8'hFE);
        send(8'h11);
        chk("bw_w0", {15'd0, write}, 16'd1);
        chk("bw_a0", {10'd0, addr}, 16'd62);
        chk("bw_d0", {8'd0, data_write}, 16'h11);
        send(8'h22);
        chk("bw_w1", {15'd0, write}, 16'd1);
        chk("bw_a1", {10'd0, addr}, 16'd63);
        chk("bw_d1", {8'd0, data_write}, 16'h22);
        send(8'h33);
        chk("bw_w2", {15'd0, write}, 16'd1);
        chk("bw_a2", {10'd0, addr}, 16'd0);
        chk("bw_d2", {8'd0, data_write}, 16'h33);
        chk("bw_busy", {15'd0, busy}, 16'd1);
        chk("bw_dout_hold", {8'd0, data_out}, 16'h77);
        frame(1'b0, 8'h00);
        chk("bw_fe_idle", {15'd0, busy}, 16'd0);

        // Burst read to limit: 0x40 + 5 dummies
        send(8'h40);
        chk("br_r0", {15'd0, read}, 16'd1);
        chk("br_a0", {10'd0, addr}, 16'd0);
        send(8'h00);
        chk("br_r1", {15'd0, read}, 16'd1);
        chk("br_a1", {10'd0, addr}, 16'd1);
        chk("br_o0", {8'd0, data_out}, 16'hA0);
        send(8'h00);
        chk("br_r2", {15'd0, read}, 16'd1);
        chk("br_a2", {10'd0, addr}, 16'd2);
        chk("br_o1", {8'd0, data_out}, 16'hA1);
        send(8'h00);
        chk("br_r3", {15'd0, read}, 16'd1);
        chk("br_a3", {10'd0, addr}, 16'd3);
        chk("br_o2", {8'd0, data_out}, 16'hA2);
        send(8'h00);
        chk("br_noread4", {15'd0, read}, 16'd0);
        chk("br_o3", {8'd0, data_out}, 16'hA3);
        chk("br_noovf4", {15'd0, ovf}, 16'd0);
        chk("br_busy_drop", {15'd0, busy}, 16'd1);
        send(8'h00);
        chk("br_ovf", {15'd0, ovf}, 16'd1);
        chk("br_noread5", {15'd0, read}, 16'd0);
        chk("br_dout_zero", {8'd0, data_out}, 16'h00);
        @(negedge clk);
        chk("br_ovf_end", {15'd0, ovf}, 16'd0);
        chk("br_still_drop", {15'd0, busy}, 16'd1);
        frame(1'b0, 8'h00);
        chk("br_fe_idle", {15'd0, busy}, 16'd0);

        // Collision: byte_sync + frame_end together in WDATA
        send(8'h81);
        frame(1'b1, 8'h55);
        chk("col_nowrite", {15'd0, write}, 16'd0);
        chk("col_idle", {15'd0, busy}, 16'd0);
        @(negedge clk);
        chk("col_nowrite2", {15'd0, write}, 16'd0);
        send(8'h02);
        chk("col_cmd_read", {15'd0, read}, 16'd1);
        chk("col_cmd_addr", {10'd0, addr}, 16'd2);
        send(8'h00);
        chk("col_done", {15'd0, busy}, 16'd0);

        // Reset in the middle of a burst read
        send(8'h40);
        send(8'h00);
        chk("mr_pre_read", {15'd0, read}, 16'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_read", {15'd0, read}, 16'd0);
        chk("mr_busy", {15'd0, busy}, 16'd0);
        chk("mr_addr", {10'd0, addr}, 16'd0);
        chk("mr_dout", {8'd0, data_out}, 16'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_noread", {15'd0, read}, 16'd0);
        send(8'h83);
        send(8'h9D);
        chk("mr_write", {15'd0, write}, 16'd1);
        chk("mr_waddr", {10'd0, addr}, 16'd3);
        chk("mr_wdata", {8'd0, data_write}, 16'h9D);
        chk("mr_idle", {15'd0, busy}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
